// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit period, receiver
// state encoding and the even-parity helper also used by the 7-bit sender.
package uart_pkg;

    localparam int DATA_BITS            = 7;
    localparam int FRAME_BITS           = 10;
    localparam int CLKS_PER_BIT_DEFAULT = 60;
    localparam int IDX_W                = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    // Even-parity bit for a character: 1 when the data holds an odd number of ones.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin plus a falling-edge
// detector on the synchronized line. All flops reset to the idle (high)
// level so that reset itself never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic serial_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain and one-cycle history of the synchronized line.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= serial_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 10-bit frames (start, 7 data LSB-first, even parity,
// stop) at CLKS_PER_BIT clocks per bit (CLKS_PER_BIT must be >= 4).
// Each character is presented on rx_data with a one-cycle rx_valid strobe;
// parity_err/frame_err are updated with the strobe and held until the next.
// Optional feature: define UART_RX_PARITY_CHECK_EN to compare the parity bit;
// without it the parity slot is still timed but parity_err is tied to 0.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int               HALF      = CLKS_PER_BIT / 2;
    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic rx_s_s;
    logic fall_s;

    rx_state_e              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_valid_q;
    logic                   frame_err_q;
    logic                   busy_q;
`ifdef UART_RX_PARITY_CHECK_EN
    logic                   par_bit_q;
    logic                   parity_err_q;
`endif

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .serial_i (serial_in),
        .rx_s_o   (rx_s_s),
        .fall_o   (fall_s)
    );

    // Frame-recovery FSM: the counter restarts at every sample point, so the
    // start sample lands HALF cycles after the edge and each later sample
    // exactly one bit period after the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Start in WAIT_HIGH so a low line at reset release is not taken as a start bit.
            state_q     <= ST_WAIT_HIGH;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (rx_s_s) begin
                            // Line back high mid start bit: treat as a glitch.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_s, shift_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_PARITY;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_STOP;
`ifdef UART_RX_PARITY_CHECK_EN
                        par_bit_q <= rx_s_s;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q       <= '0;
                        rx_data_q   <= shift_q;
                        rx_valid_q  <= 1'b1;
                        frame_err_q <= ~rx_s_s;
                        busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
                        parity_err_q <= par_bit_q ^ even_parity(shift_q);
`endif
                        // A low stop bit (e.g. break) must see the line high before re-arming.
                        state_q <= rx_s_s ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_WAIT_HIGH;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_CHECK_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage, the downstream counterpart of the team's 7-bit UART sender. Samples an asynchronous serial line, recovers 10-bit frames (start, 7 data bits LSB-first, even parity, stop) at a fixed bit period and presents each character as a parallel word with a one-cycle valid strobe and error flags. Sits between the board RX pin and the character-consuming logic.

## Interface
- CLKS_PER_BIT, 60, clock cycles per serial bit (3000 ns bit time at 50 ns clock); must be >= 4
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- serial_in  input  1  asynchronous serial line, idle high
- rx_data  output  7  last received character, bit 0 = first data bit on the line
- rx_valid  output  1  one-cycle strobe: rx_data and flags updated this cycle
- parity_err  output  1  received parity bit != XOR of rx_data bits; valid with rx_valid, held until next rx_valid
- frame_err  output  1  stop bit sampled 0; valid with rx_valid, held until next rx_valid
- busy  output  1  high from start-edge detection until return to IDLE

## Operation
- serial_in passes through a 2-flop synchronizer (reset value 1) to give rx_s; falling-edge detect on rx_s (previous 1, current 0) at cycle T0.
- HALF = CLKS_PER_BIT/2 (integer floor). One bit-period counter, one bit index 0..6.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on falling edge -> START, counter cleared, busy=1.
- START: sample rx_s at T0+HALF; if 1 (glitch) -> IDLE, no strobe; if 0 -> DATA.
- DATA: bit k sampled at T0+HALF+(k+1)*CLKS_PER_BIT, shifted in LSB-first; after k=6 -> PARITY.
- PARITY: sample at T0+HALF+8*CLKS_PER_BIT; compare with XOR of the 7 data bits (even parity: bit = 1 when data has odd count of ones).
- STOP: sample at T0+HALF+9*CLKS_PER_BIT. Next cycle: rx_data, parity_err, frame_err loaded, rx_valid=1. Stop=1 -> IDLE; stop=0 -> WAIT_HIGH.
- WAIT_HIGH: no edge detection until rx_s=1, then IDLE. Break conditions therefore yield exactly one frame_err strobe.
- Character is always delivered on rx_valid even when flags are set; consumer decides.
- No backpressure: an unread character is overwritten by the next rx_valid.

## Timing
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0, state=WAIT_HIGH (prevents arming on a mid-frame low after reset), synchronizer flops=1.
- Pin-to-rx_s latency 2 cycles.
- rx_valid at T0+HALF+9*CLKS_PER_BIT+1, exactly one cycle; busy deasserts that same cycle (state IDLE, or WAIT_HIGH with busy=0).
- A new falling edge is accepted from the cycle after rx_valid; back-to-back frames with a one-bit stop are received without loss.
- rst asserted in any state: at the next edge all outputs to reset values; partial frame discarded, no strobe.
- rx_s returning high mid-DATA is not checked; only start, parity and stop samples are qualified.

## Configuration
- UART_RX_PARITY_CHECK_EN defined: parity compared, parity_err driven as above.
- Undefined: parity bit slot still timed and sampled (frame length unchanged), comparison logic removed, parity_err constant 0.

## Structure
- Shared package uart_pkg: DATA_BITS=7, FRAME_BITS=10, default CLKS_PER_BIT=60, receiver state encoding, even-parity function shared with the sender.
- Sub-module uart_rx_sync: 2-flop synchronizer plus falling-edge detect, outputs rx_s and fall pulse; reset drives both flops to 1.

## Test plan
- CLKS_PER_BIT=8, frame 7'h55, parity 0, stop 1 -> rx_data=7'h55, parity_err=0, frame_err=0, rx_valid exactly at T0+4+72+1.
- Frame 7'h01 with parity 0 -> rx_data=7'h01, parity_err=1 with macro, 0 without; frame_err=0.
- Frame 7'h7F, stop bit 0, line held low 30 cycles -> one rx_valid with frame_err=1; no second strobe until line high and a new start arrives.
- 3-cycle low glitch on idle line -> busy pulses ~4 cycles, returns to IDLE, no rx_valid.
- rst pulse during DATA bit 3, line released -> no rx_valid, outputs 0; next full frame 7'h2A received correctly.
- Two back-to-back frames 7'h12 then 7'h6D, no idle gap -> two rx_valid strobes, correct data, no errors.
